// File: rtl/q_update_ctrl_if.sv
// Handshake, Q-table port and updater operand bundle for the Q-learning update sequencer.
// master = the sequencer, slave = the surrounding learner, RAM and updater datapath.
interface q_update_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int N_ACT  = 9,
    parameter int Q_W    = 16
);
    logic              start;
    logic [ADDR_W-1:0] state_idx;
    logic [3:0]        action;
    logic [ADDR_W-1:0] next_idx;
    logic [N_ACT-1:0]  next_mask;
    logic              terminal;
    logic [Q_W-1:0]    reward_in;
    logic [3:0]        gamma_in;
    logic [3:0]        alpha_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [Q_W-1:0]    mem_rd_data;
    logic              mem_wr_en;
    logic [Q_W-1:0]    mem_wr_data;
    logic [Q_W-1:0]    upd_q;
    logic [Q_W-1:0]    upd_qmax;
    logic [Q_W-1:0]    upd_reward;
    logic [3:0]        upd_gamma;
    logic [3:0]        upd_alpha;
    logic [Q_W-1:0]    upd_qnew;

    modport master (
        input  start, state_idx, action, next_idx, next_mask, terminal,
               reward_in, gamma_in, alpha_in, mem_rd_data, upd_qnew,
        output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
               upd_q, upd_qmax, upd_reward, upd_gamma, upd_alpha
    );

    modport slave (
        output start, state_idx, action, next_idx, next_mask, terminal,
               reward_in, gamma_in, alpha_in, mem_rd_data, upd_qnew,
        input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
               upd_q, upd_qmax, upd_reward, upd_gamma, upd_alpha
    );
endinterface

// File: rtl/q_update_ctrl.sv
// Sequencer for one tabular Q-learning step: read Q(s,a), scan max legal Q(s',*),
// hand operands to the combinational updater, write Q_new back.
module q_update_ctrl #(
    parameter int ADDR_W = 15,
    parameter int N_ACT  = 9,
    parameter int Q_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    q_update_ctrl_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_Q  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;
    localparam logic [2:0] S_CALC  = 3'd5;
    localparam logic [2:0] S_WR    = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [3:0]     LAST_ACT = 4'(N_ACT - 1);
    localparam logic [Q_W-1:0] Q_MIN    = {1'b1, {(Q_W-1){1'b0}}};

    logic [2:0]        r_state;
    logic [3:0]        r_k;
    logic [ADDR_W-1:0] r_state_idx;
    logic [3:0]        r_action;
    logic [ADDR_W-1:0] r_next_idx;
    logic [N_ACT-1:0]  r_next_mask;
    logic              r_terminal;
    logic [Q_W-1:0]    r_q_cur;
    logic [Q_W-1:0]    r_qmax;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd_en;
    logic              r_mem_wr_en;
    logic [Q_W-1:0]    r_mem_wr_data;
    logic [Q_W-1:0]    r_upd_reward;
    logic [3:0]        r_upd_gamma;
    logic [3:0]        r_upd_alpha;

    logic [3:0]        w_cand_act;
    logic              w_cand_vld;
    logic              w_take;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] idx,
                                                  input logic [3:0]        k);
        return idx * ADDR_W'(N_ACT) + ADDR_W'(k);
    endfunction

    // Read data lags the address by one cycle, so the word arriving now belongs to
    // action k-1; DRAIN collects the final action after the last address went out.
    assign w_cand_act = (r_state == S_DRAIN) ? LAST_ACT : (r_k - 4'd1);
    assign w_cand_vld = (r_state == S_DRAIN) || ((r_state == S_SCAN) && (r_k != 4'd0));
    assign w_take     = w_cand_vld && r_next_mask[w_cand_act] &&
                        ($signed(bus.mem_rd_data) > $signed(r_qmax));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_state_idx   <= '0;
            r_action      <= '0;
            r_next_idx    <= '0;
            r_next_mask   <= '0;
            r_terminal    <= 1'b0;
            r_q_cur       <= '0;
            r_qmax        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= '0;
            r_upd_reward  <= '0;
            r_upd_gamma   <= '0;
            r_upd_alpha   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.action > LAST_ACT) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state_idx  <= bus.state_idx;
                            r_action     <= bus.action;
                            r_next_idx   <= bus.next_idx;
                            r_next_mask  <= bus.next_mask;
                            r_terminal   <= bus.terminal;
                            r_upd_reward <= bus.reward_in;
                            r_upd_gamma  <= bus.gamma_in;
                            r_upd_alpha  <= bus.alpha_in;
                            r_busy       <= 1'b1;
                            r_mem_rd_en  <= 1'b1;
                            r_mem_addr   <= addr_of(bus.state_idx, bus.action);
                            r_state      <= S_RD_Q;
                        end
                    end
                end
                S_RD_Q: begin
                    r_qmax <= Q_MIN;
                    if (r_terminal || (r_next_mask == '0)) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_CAP;
                    end else begin
                        r_k        <= 4'd0;
                        r_mem_addr <= addr_of(r_next_idx, 4'd0);
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_k == 4'd0) begin
                        r_q_cur <= bus.mem_rd_data;
                    end else if (w_take) begin
                        r_qmax <= bus.mem_rd_data;
                    end
                    if (r_k == LAST_ACT) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_k        <= r_k + 4'd1;
                        r_mem_addr <= addr_of(r_next_idx, r_k + 4'd1);
                    end
                end
                S_DRAIN: begin
                    if (w_take) begin
                        r_qmax <= bus.mem_rd_data;
                    end
                    r_state <= S_CALC;
                end
                S_CAP: begin
                    r_q_cur <= bus.mem_rd_data;
                    r_qmax  <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    // Updater operands have been stable for this whole cycle.
                    r_mem_wr_data <= bus.upd_qnew;
                    r_mem_wr_en   <= 1'b1;
                    r_mem_addr    <= addr_of(r_state_idx, r_action);
                    r_state       <= S_WR;
                end
                S_WR: begin
                    r_mem_wr_en <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.upd_q       = r_q_cur;
    assign bus.upd_qmax    = r_qmax;
    assign bus.upd_reward  = r_upd_reward;
    assign bus.upd_gamma   = r_upd_gamma;
    assign bus.upd_alpha   = r_upd_alpha;
endmodule
